execute_stage: RTL and testbench
================================

# execute_stage

Pipeline stage between decode and `memory`. Registers the decode bundle and runs the ALU, a single-cycle multiplier, an iterative divider and branch/jump resolution. It produces the `e_to_m_bus` consumed by `memory`, a hazard bus and a forwarding value. It raises `stall_request_o` while a divide is in progress.

## Interface
- No parameters; bus widths come from `cpu_defs.vh` (`D_TO_E_BUS_WD`, `E_TO_M_BUS_WD`=134, `E_TO_H_BUS_WD`=7).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- previous_valid_i  in  1  decode holds a valid instruction.
- current_valid_o  out  1  execute stage valid.
- stall_execute  in  1  hold the stage register (from the hazard unit).
- flush_execute  in  1  clear the stage register to a bubble.
- d_to_e_bus  in  D_TO_E_BUS_WD  fields, MSB first:
  - alu_op[4:0], use_imm, use_pc, branch_op[2:0], is_jal, is_jalr
  - mem_load, mem_store, mem_access_size[1:0], load_signext
  - rf_write_en, rf_dest[4:0]
  - rs1_data[31:0], rs2_data[31:0], imm[31:0], pc[31:0]
- e_to_m_bus  out  134  fields, MSB first: mem_load, mem_store, mem_access_size[1:0], load_signext, rf_write_en, rf_dest[31:0] (upper 27 bits zero), rs2_data, result, pc.
- e_to_h_bus  out  7  {mem_load, rf_dest[4:0], rf_write_en}.
- forward_result_execute  out  32  equals the result field.
- stall_request_o  out  1  divider not finished.
- branch_taken_o  out  1  redirect fetch.
- branch_target_o  out  32  redirect address.

## Operation
- Stage register (bus and valid):
  - cleared on reset or flush_execute;
  - loaded when !stall_execute;
  - flush has priority over stall.
- Operands:
  - A = use_pc ? pc : rs1_data.
  - B = use_imm ? imm : rs2_data.
- ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, LUI(pass B).
  - Shift amount is B[4:0].
  - Arithmetic is 32-bit, wraps, no overflow flag.
- Multiply: MUL, MULH, MULHSU, MULHU are combinational 64-bit products; MUL returns [31:0], the others return [63:32].
- Divide: DIV, DIVU, REM, REMU go through the `div_unit` FSM (IDLE, BUSY, DONE).
  - IDLE→BUSY when the stage is valid, holds a div op, and the divisor is nonzero and not signed overflow.
  - BUSY runs 32 iterations of radix-2 restoring division on magnitudes; the counter goes 0..31.
  - After iteration 31, BUSY→DONE and the sign is fixed up:
    - quotient negated if the operand signs differ (signed ops only);
    - remainder takes the dividend's sign.
  - DONE holds the result until the stage register loads (!stall_execute), then DONE→IDLE.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. No FSM entry, zero stall.
  - Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0. Zero stall.
  - flush_execute or reset in any state → IDLE, partial result discarded.
- stall_request_o = valid & div_op & !special_case & (state != DONE).
- Branch resolution: compare rs1_data and rs2_data.
  - branch_op values: BEQ, BNE, BLT, BGE, BLTU, BGEU, NONE.
  - branch_taken_o = valid & (cond | is_jal | is_jalr).
  - Branch and JAL target: pc + imm.
  - JALR target: (rs1_data + imm) & ~1.
  - For JAL and JALR, result = pc + 4.
- Invalid stage: branch_taken_o = 0, stall_request_o = 0. The bus passes whatever the register holds; `memory` gates on valid.

## Timing
- Reset values: current_valid_o=0, e_to_m_bus=0, e_to_h_bus=0, forward=0, stall_request_o=0, branch_taken_o=0, branch_target_o=0. Divider state is IDLE.
- Non-divide ops: result valid in the same cycle the stage register holds the instruction, so latency through the stage is 1 clock.
- Divide latency, with cycle 0 = the first cycle the instruction sits in execute:
  - cycle 0: IDLE→BUSY;
  - cycles 1–32: iterations;
  - cycle 33: DONE, stall_request_o low;
  - stall_request_o is high for cycles 0–32 (33 cycles).
- Back-to-back divides: the FSM goes DONE→IDLE on the advance edge, so the next divide starts in its own cycle 0.
- If stall_execute is held while in DONE, the result stays stable.

## Structure
- `cpu_defs.vh` holds:
  - the alu_op and branch_op encodings;
  - mem_access_size encoding: bit0 = byte, bit1 = half, 00 = word;
  - all bus widths.
- Sub-module `div_unit`:
  - start, signed, op_rem, dividend, divisor, flush → busy, done, result, with an ack input;
  - about 120 lines.
- `execute_stage` holds the stage register, ALU, multiplier and branch logic.

## Test plan
- ADD 0x7FFFFFFF + 1 → result 0x80000000 on e_to_m_bus one cycle after load; stall_request_o 0.
- DIV −7 / 2 → quotient −3 (0xFFFFFFFD); REM −7 % 2 → −1. stall_request_o high exactly 33 cycles.
- DIVU x / 0 → 0xFFFFFFFF; DIV 0x80000000 / −1 → 0x80000000. No stall cycles.
- BLT rs1=−1, rs2=1, pc=0x100, imm=0x20 → branch_taken_o=1, target 0x120. With BLTU on the same operands → taken 0.
- flush_execute in cycle 10 of a divide → FSM IDLE, stall_request_o 0 next cycle, valid 0.
- DIV completes while stall_execute is held 3 extra cycles → result stable through the hold; the next DIV starts fresh and gives a correct result.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared encodings, bus widths and bus layouts for the execute stage and its divider.
package execute_stage_pkg;

  localparam int D_TO_E_BUS_WD = 151;
  localparam int E_TO_M_BUS_WD = 134;
  localparam int E_TO_H_BUS_WD = 7;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_LUI    = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6
  } branch_op_e;

  // mem_access_size: bit0 = byte, bit1 = half, 00 = word.
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic        use_imm;
    logic        use_pc;
    branch_op_e  branch_op;
    logic        is_jal;
    logic        is_jalr;
    logic        mem_load;
    logic        mem_store;
    logic [1:0]  mem_access_size;
    logic        load_signext;
    logic        rf_write_en;
    logic [4:0]  rf_dest;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
  } d_to_e_t;

  typedef struct packed {
    logic        mem_load;
    logic        mem_store;
    logic [1:0]  mem_access_size;
    logic        load_signext;
    logic        rf_write_en;
    logic [31:0] rf_dest;
    logic [31:0] rs2_data;
    logic [31:0] result;
    logic [31:0] pc;
  } e_to_m_t;

  function automatic logic is_div_op(alu_op_e op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/execute_stage_div.sv
// Iterative radix-2 restoring divider on operand magnitudes, sign fixed up on the last step.
module div_unit
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        op_rem,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        flush,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_e  state;
  logic [31:0] quo, rem, dvs;
  logic [4:0]  count;
  logic        neg_q, neg_r, want_rem;
  logic [32:0] rem_shift;
  logic        fits;
  logic [31:0] quo_next, rem_next;

  function automatic logic [31:0] mag(logic neg, logic [31:0] v);
    return neg ? -v : v;
  endfunction

  // The quotient register doubles as the dividend shift register.
  always_comb begin
    rem_shift = {rem, quo[31]};
    fits      = rem_shift >= {1'b0, dvs};
    quo_next  = {quo[30:0], fits};
    rem_next  = fits ? 32'(rem_shift - {1'b0, dvs}) : rem_shift[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state    <= DIV_IDLE;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      count    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          state    <= DIV_BUSY;
          quo      <= mag(is_signed & dividend[31], dividend);
          rem      <= '0;
          dvs      <= mag(is_signed & divisor[31], divisor);
          count    <= '0;
          neg_q    <= is_signed & (dividend[31] ^ divisor[31]);
          neg_r    <= is_signed & dividend[31];
          want_rem <= op_rem;
        end
        DIV_BUSY: begin
          quo   <= quo_next;
          rem   <= rem_next;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state  <= DIV_DONE;
            result <= want_rem ? mag(neg_r, rem_next) : mag(neg_q, quo_next);
          end
        end
        DIV_DONE: if (ack) state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: stage register, ALU, multiplier, divider control and branch resolution.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     previous_valid_i,
  output logic                     current_valid_o,
  input  logic                     stall_execute,
  input  logic                     flush_execute,
  input  logic [D_TO_E_BUS_WD-1:0] d_to_e_bus,
  output logic [E_TO_M_BUS_WD-1:0] e_to_m_bus,
  output logic [E_TO_H_BUS_WD-1:0] e_to_h_bus,
  output logic [31:0]              forward_result_execute,
  output logic                     stall_request_o,
  output logic                     branch_taken_o,
  output logic [31:0]              branch_target_o
);

  d_to_e_t     s;
  logic        valid;
  logic [31:0] op_a, op_b, result, special_result, div_result;
  logic        div_signed, div_rem, div_special, div_active, div_busy, div_done, cond;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;
  e_to_m_t     out;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush_execute) begin
      valid <= 1'b0;
      s     <= '0;
    end else if (!stall_execute) begin
      valid <= previous_valid_i;
      s     <= d_to_e_t'(d_to_e_bus);
    end
  end

  assign op_a = s.use_pc  ? s.pc  : s.rs1_data;
  assign op_b = s.use_imm ? s.imm : s.rs2_data;

  // One 33x33 signed multiplier covers all four variants via per-operand sign extension.
  assign mul_a = {(s.alu_op == ALU_MULH || s.alu_op == ALU_MULHSU) & op_a[31], op_a};
  assign mul_b = {(s.alu_op == ALU_MULH) & op_b[31], op_b};
  assign prod  = 64'(mul_a) * 64'(mul_b);

  assign div_signed     = (s.alu_op == ALU_DIV) || (s.alu_op == ALU_REM);
  assign div_rem        = (s.alu_op == ALU_REM) || (s.alu_op == ALU_REMU);
  assign div_special    = (op_b == 32'd0) ||
                          (div_signed && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF);
  assign special_result = (op_b == 32'd0) ? (div_rem ? op_a : 32'hFFFF_FFFF)
                                          : (div_rem ? 32'd0 : 32'h8000_0000);
  assign div_active     = valid && is_div_op(s.alu_op) && !div_special;

  div_unit u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_active),
    .is_signed(div_signed),
    .op_rem   (div_rem),
    .dividend (op_a),
    .divisor  (op_b),
    .flush    (flush_execute),
    .ack      (!stall_execute),
    .busy     (div_busy),
    .done     (div_done),
    .result   (div_result)
  );

  // High from the first execute cycle until the divider reaches DONE.
  assign stall_request_o = div_active && (div_busy || !div_done);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    result = '0;
    case (s.alu_op)
      ALU_ADD:    result = op_a + op_b;
      ALU_SUB:    result = op_a - op_b;
      ALU_AND:    result = op_a & op_b;
      ALU_OR:     result = op_a | op_b;
      ALU_XOR:    result = op_a ^ op_b;
      ALU_SLL:    result = op_a << op_b[4:0];
      ALU_SRL:    result = op_a >> op_b[4:0];
      ALU_SRA:    result = $signed(op_a) >>> op_b[4:0];
      ALU_SLT:    result = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   result = {31'd0, op_a < op_b};
      ALU_LUI:    result = op_b;
      ALU_MUL:    result = prod[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod[63:32];
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:
                  result = div_special ? special_result : div_result;
      default:    result = '0;
    endcase
    if (s.is_jal || s.is_jalr) result = s.pc + 32'd4;
  end

  always_comb begin
    cond = 1'b0;
    case (s.branch_op)
      BR_BEQ:  cond = s.rs1_data == s.rs2_data;
      BR_BNE:  cond = s.rs1_data != s.rs2_data;
      BR_BLT:  cond = $signed(s.rs1_data) <  $signed(s.rs2_data);
      BR_BGE:  cond = $signed(s.rs1_data) >= $signed(s.rs2_data);
      BR_BLTU: cond = s.rs1_data <  s.rs2_data;
      BR_BGEU: cond = s.rs1_data >= s.rs2_data;
      default: cond = 1'b0;
    endcase
  end

  assign branch_taken_o  = valid && (cond || s.is_jal || s.is_jalr);
  assign branch_target_o = s.is_jalr ? ((s.rs1_data + s.imm) & ~32'd1) : (s.pc + s.imm);

  always_comb begin
    out.mem_load        = s.mem_load;
    out.mem_store       = s.mem_store;
    out.mem_access_size = s.mem_access_size;
    out.load_signext    = s.load_signext;
    out.rf_write_en     = s.rf_write_en;
    out.rf_dest         = {27'd0, s.rf_dest};
    out.rs2_data        = s.rs2_data;
    out.result          = result;
    out.pc              = s.pc;
  end

  assign e_to_m_bus             = out;
  assign e_to_h_bus             = {s.mem_load, s.rf_dest, s.rf_write_en};
  assign forward_result_execute = result;
  assign current_valid_o        = valid;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; the hazard unit is modelled as stall_execute = stall_request_o | hold.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic         clk = 1'b0;
  logic         reset, previous_valid, flush, hold;
  logic         stall_execute, current_valid, stall_request, branch_taken;
  d_to_e_t      dbus;
  logic [133:0] em;
  logic [6:0]   eh;
  logic [31:0]  fwd, target;
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  assign stall_execute = stall_request | hold;

  execute_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .previous_valid_i      (previous_valid),
    .current_valid_o       (current_valid),
    .stall_execute         (stall_execute),
    .flush_execute         (flush),
    .d_to_e_bus            (dbus),
    .e_to_m_bus            (em),
    .e_to_h_bus            (eh),
    .forward_result_execute(fwd),
    .stall_request_o       (stall_request),
    .branch_taken_o        (branch_taken),
    .branch_target_o       (target)
  );

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic d_to_e_t mk(alu_op_e op, logic [31:0] rs1, logic [31:0] rs2,
                                 logic [31:0] imm, logic [31:0] pc);
    d_to_e_t d = '0;
    d.alu_op      = op;
    d.branch_op   = BR_NONE;
    d.rf_write_en = 1'b1;
    d.rf_dest     = 5'd1;
    d.rs1_data    = rs1;
    d.rs2_data    = rs2;
    d.imm         = imm;
    d.pc          = pc;
    return d;
  endfunction

  // Present an instruction and advance one edge; afterwards it sits in execute.
  task automatic load(input d_to_e_t d, input logic v);
    dbus           = d;
    previous_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic run_alu(input string tag, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    load(mk(op, a, b, 32'd0, 32'd0), 1'b1);
    check(tag, em[63:32], exp);
  endtask

  task automatic wait_div(input string tag, input logic [31:0] exp);
    int n = 0;
    while (stall_request && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_stall_cycles"}, n, 33);
    check(tag, em[63:32], exp);
  endtask

  task automatic run_div(input string tag, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    load(mk(op, a, b, 32'd0, 32'd0), 1'b1);
    wait_div(tag, exp);
  endtask

  task automatic run_special(input string tag, input alu_op_e op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
    load(mk(op, a, b, 32'd0, 32'd0), 1'b1);
    check({tag, "_stall"}, stall_request, 1'b0);
    check(tag, em[63:32], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d_to_e_t d;
    reset = 1'b1; flush = 1'b0; hold = 1'b0; previous_valid = 1'b1;
    dbus  = mk(ALU_ADD, 32'h1111_1111, 32'h2222_2222, 32'h3, 32'h44);
    dbus.is_jal = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  current_valid, 1'b0);
    check("rst_e_to_m", em, '0);
    check("rst_e_to_h", eh, '0);
    check("rst_fwd",    fwd, '0);
    check("rst_stall",  stall_request, 1'b0);
    check("rst_taken",  branch_taken, 1'b0);
    check("rst_target", target, '0);
    reset = 1'b0;

    // ADD with wraparound plus side-band passthrough.
    d = mk(ALU_ADD, 32'h7FFF_FFFF, 32'hAABB_CCDD, 32'd1, 32'h40);
    d.use_imm = 1'b1; d.rf_dest = 5'd5; d.mem_store = 1'b1; d.mem_access_size = SIZE_BYTE;
    load(d, 1'b1);
    check("add_e_to_m", em, {1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'd5, 32'hAABB_CCDD,
                             32'h8000_0000, 32'h0000_0040});
    check("add_fwd",   fwd, 32'h8000_0000);
    check("add_e_to_h", eh, 7'h0B);
    check("add_valid", current_valid, 1'b1);
    check("add_stall", stall_request, 1'b0);
    check("add_taken", branch_taken, 1'b0);

    run_alu("sub",    ALU_SUB,    32'd5,         32'd7,         32'hFFFF_FFFE);
    run_alu("xor",    ALU_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    run_alu("sll31",  ALU_SLL,    32'd1,         32'h0000_003F, 32'h8000_0000);
    run_alu("sra",    ALU_SRA,    32'h8000_0010, 32'd4,         32'hF800_0001);
    run_alu("srl",    ALU_SRL,    32'h8000_0010, 32'd4,         32'h0800_0001);
    run_alu("slt",    ALU_SLT,    32'hFFFF_FFFF, 32'd1,         32'd1);
    run_alu("sltu",   ALU_SLTU,   32'hFFFF_FFFF, 32'd1,         32'd0);
    run_alu("mul",    ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    run_alu("mulh",   ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    run_alu("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_alu("mulhu",  ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    d = mk(ALU_LUI, 32'h0, 32'h0, 32'h1234_5000, 32'h0); d.use_imm = 1'b1;
    load(d, 1'b1);
    check("lui", em[63:32], 32'h1234_5000);
    d = mk(ALU_ADD, 32'h0, 32'h0, 32'h10, 32'h1000); d.use_imm = 1'b1; d.use_pc = 1'b1;
    load(d, 1'b1);
    check("auipc", em[63:32], 32'h1010);

    // Branches and jumps.
    d = mk(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100); d.branch_op = BR_BLT;
    load(d, 1'b1);
    check("blt_taken",  branch_taken, 1'b1);
    check("blt_target", target, 32'h120);
    d.branch_op = BR_BLTU;
    load(d, 1'b1);
    check("bltu_taken", branch_taken, 1'b0);
    d = mk(ALU_ADD, 32'h201, 32'd0, 32'h10, 32'h500); d.is_jalr = 1'b1;
    load(d, 1'b1);
    check("jalr_taken",  branch_taken, 1'b1);
    check("jalr_target", target, 32'h210);
    check("jalr_link",   em[63:32], 32'h504);
    d = mk(ALU_ADD, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h300); d.is_jal = 1'b1;
    load(d, 1'b1);
    check("jal_target", target, 32'h2F8);
    check("jal_link",   em[63:32], 32'h304);
    d = mk(ALU_ADD, 32'd9, 32'd9, 32'h8, 32'h0); d.branch_op = BR_BEQ;
    load(d, 1'b0);
    check("invalid_taken", branch_taken, 1'b0);
    check("invalid_valid", current_valid, 1'b0);
    d = mk(ALU_DIV, 32'd7, 32'd2, 32'h0, 32'h0);
    load(d, 1'b0);
    check("invalid_div_stall", stall_request, 1'b0);

    // Iterative divides.
    run_div("div_neg7_2", ALU_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_div("rem_neg7_2", ALU_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_div("div_7_neg2", ALU_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_div("rem_7_neg2", ALU_REM,  32'd7,         32'hFFFF_FFFE, 32'd1);
    run_div("divu_max",   ALU_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF);
    run_div("remu_max",   ALU_REMU, 32'hFFFF_FFFF, 32'd10,        32'd5);

    // Special cases take no stall cycles.
    run_special("divu_zero", ALU_DIVU, 32'h1234, 32'd0,         32'hFFFF_FFFF);
    run_special("remu_zero", ALU_REMU, 32'h1234, 32'd0,         32'h1234);
    run_special("div_ovf",   ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_special("rem_ovf",   ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush in cycle 10 of a divide.
    load(mk(ALU_DIV, 32'd100, 32'd7, 32'h0, 32'h0), 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("pre_flush_stall", stall_request, 1'b1);
    flush = 1'b1; previous_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", current_valid, 1'b0);
    check("flush_stall", stall_request, 1'b0);

    // Completion held by an external stall, then a fresh divide.
    run_div("div_100_7", ALU_DIV, 32'd100, 32'd7, 32'd14);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_result", em[63:32], 32'd14);
      check("hold_stall",  stall_request, 1'b0);
    end
    dbus = mk(ALU_DIV, 32'hFFFF_FF9C, 32'd7, 32'h0, 32'h0);
    hold = 1'b0;
    @(posedge clk); #1;
    wait_div("div_neg100_7", 32'hFFFF_FFF2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
